// File: rtl/core_pkg.sv
// core_pkg: shared sequencer state encoding, supported opcodes and the opcode filter
package core_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    function automatic logic is_supported(input logic [6:0] op);
        return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE};
    endfunction

endpackage

// File: rtl/req_timeout.sv
// req_timeout: 16-bit pending-request counter with clear/enable and a limit-hit flag
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the count (takes priority over en)
//   en       : a request is pending without ready this cycle
//   hit      : count has reached LIMIT
module req_timeout #(
    parameter logic [15:0] LIMIT = 16'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [15:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? 16'd0 : en ? cnt_q + 16'd1 : cnt_q;

    assign hit = cnt_q == LIMIT;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/exec/mem/wb sequencer for the rv32 multicycle datapath
//   clk, rst                 : clock, synchronous active-high reset
//   opcode                   : instr[6:0] from the IR, valid from DECODE onward
//   imem_ready, dmem_ready   : memory completes the access this cycle
//   imem_req, dmem_req, dmem_we : memory requests (combinational from state)
//   ir_write, pc_write, mdr_write, rf_write, wb_sel : datapath write strobes and WB select
//   halted, illegal_insn, bus_error : sticky stop status
//   state                    : current state encoding
//   retired                  : retired-instruction count, wraps silently
module multicycle_sequencer
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETIRE_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic                mdr_write,
    output logic                rf_write,
    output logic                wb_sel,
    output logic                halted,
    output logic                illegal_insn,
    output logic                bus_error,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    state_e                state_q, state_d;
    logic                  halted_q, halted_d;
    logic                  illegal_q, illegal_d;
    logic                  bus_error_q, bus_error_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;
    logic                  is_load, is_store, legal, rdy, wait_rdy, hit, tmo, retire;

    assign is_load  = opcode == OP_LOAD;
    assign is_store = opcode == OP_STORE;
    assign legal    = is_supported(opcode);

    always_comb begin
        imem_req  = state_q == S_FETCH;
        dmem_req  = state_q == S_MEM;
        dmem_we   = dmem_req && is_store;
        rdy       = (imem_req && imem_ready) || (dmem_req && dmem_ready);
        wait_rdy  = (imem_req || dmem_req) && !rdy;
        // a ready on the limit cycle completes normally, so only a still-waiting request times out
        tmo       = wait_rdy && hit;
        ir_write  = imem_req && imem_ready;
        mdr_write = dmem_req && dmem_ready && is_load;
        rf_write  = state_q == S_WB;
        wb_sel    = rf_write && is_load;
        retire    = rf_write || (dmem_we && dmem_ready);
        pc_write  = retire;
        state_d   = state_q;
        case (state_q)
            S_FETCH:  state_d = tmo ? S_HALT : imem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = legal ? S_EXEC : S_HALT;
            S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
            S_MEM:    state_d = tmo ? S_HALT : !dmem_ready ? S_MEM : is_load ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
        halted_d    = halted_q || state_d == S_HALT;
        illegal_d   = illegal_q || (state_q == S_DECODE && !legal);
        bus_error_d = bus_error_q || tmo;
        retired_d   = retired_q + RETIRE_W'(retire);
    end

    // every handshake leaves the requesting state, so a state change also covers the handshake clear
    req_timeout #(
        .LIMIT(16'(TIMEOUT_CYCLES))
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (state_d != state_q),
        .en  (wait_rdy),
        .hit (hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
            retired_q   <= retired_d;
        end
    end

    assign state        = state_q;
    assign halted       = halted_q;
    assign illegal_insn = illegal_q;
    assign bus_error    = bus_error_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011;
    localparam logic [6:0] BAD   = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = R_OP;
    logic        imem_ready = 1'b1;
    logic        dmem_ready = 1'b1;
    logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, mdr_write, rf_write, wb_sel;
    logic        halted, illegal_insn, bus_error;
    logic [2:0]  state;
    logic [31:0] retired;

    int n_chk = 0;
    int n_bad = 0;

    multicycle_sequencer #(
        .TIMEOUT_CYCLES(4),
        .RETIRE_W(32)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_write(ir_write), .pc_write(pc_write), .mdr_write(mdr_write),
        .rf_write(rf_write), .wb_sel(wb_sel),
        .halted(halted), .illegal_insn(illegal_insn), .bus_error(bus_error),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr;
        int n;
        step();
        step();
        chk("rst_state", 32'(state), 0);
        chk("rst_retired", retired, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal_insn), 0);
        chk("rst_buserr", 32'(bus_error), 0);
        chk("rst_rfw", 32'(rf_write), 0);
        rst = 1'b0;
        #1;
        chk("t1_fetch", 32'(state), 0);
        chk("t1_irw", 32'(ir_write), 1);
        chk("t1_pcw1", 32'(pc_write), 0);
        step();
        chk("t1_decode", 32'(state), 1);
        chk("t1_pcw2", 32'(pc_write), 0);
        step();
        chk("t1_exec", 32'(state), 2);
        chk("t1_rfw3", 32'(rf_write), 0);
        step();
        chk("t1_wb", 32'(state), 4);
        chk("t1_rfw4", 32'(rf_write), 1);
        chk("t1_pcw4", 32'(pc_write), 1);
        chk("t1_wbsel", 32'(wb_sel), 0);
        step();
        chk("t1_back", 32'(state), 0);
        chk("t1_ret1", retired, 1);
        wr = 0;
        for (int i = 0; i < 36; i++) begin
            if (rf_write) wr++;
            step();
        end
        chk("t1_ret10", retired, 10);
        chk("t1_rfw_cnt", 32'(wr), 9);

        opcode = LD_OP;
        dmem_ready = 1'b0;
        step();
        step();
        step();
        chk("t2_mem", 32'(state), 3);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (dmem_req) n++;
            chk("t2_we", 32'(dmem_we), 0);
            chk("t2_nomdr", 32'(mdr_write), 0);
            step();
        end
        dmem_ready = 1'b1;
        #1;
        if (dmem_req) n++;
        chk("t2_mdrw", 32'(mdr_write), 1);
        chk("t2_req_cycles", 32'(n), 4);
        step();
        chk("t2_wb", 32'(state), 4);
        chk("t2_wbsel", 32'(wb_sel), 1);
        chk("t2_rfw", 32'(rf_write), 1);
        step();
        chk("t2_ret", retired, 11);

        opcode = ST_OP;
        step();
        step();
        step();
        chk("t3_mem", 32'(state), 3);
        chk("t3_req", 32'(dmem_req), 1);
        chk("t3_we", 32'(dmem_we), 1);
        chk("t3_pcw", 32'(pc_write), 1);
        chk("t3_rfw", 32'(rf_write), 0);
        step();
        chk("t3_fetch", 32'(state), 0);
        chk("t3_noreq", 32'(dmem_req), 0);
        chk("t3_ret", retired, 12);

        opcode = BAD;
        step();
        chk("t4_decode", 32'(state), 1);
        chk("t4_nopcw", 32'(pc_write), 0);
        step();
        chk("t4_halt", 32'(state), 5);
        chk("t4_halted", 32'(halted), 1);
        chk("t4_illegal", 32'(illegal_insn), 1);
        chk("t4_buserr", 32'(bus_error), 0);
        chk("t4_noireq", 32'(imem_req), 0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_stay", 32'(state), 5);
        end
        chk("t4_ret", retired, 12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_rst_state", 32'(state), 0);
        chk("t4_rst_halted", 32'(halted), 0);
        chk("t4_rst_illegal", 32'(illegal_insn), 0);

        opcode = R_OP;
        imem_ready = 1'b0;
        n = 0;
        while (state == 3'd0 && n < 20) begin
            n++;
            step();
        end
        chk("t5_req_cycles", 32'(n), 5);
        chk("t5_halt", 32'(state), 5);
        chk("t5_buserr", 32'(bus_error), 1);
        chk("t5_illegal", 32'(illegal_insn), 0);
        chk("t5_halted", 32'(halted), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t5b_wait", 32'(state), 0);
        imem_ready = 1'b1;
        #1;
        chk("t5b_irw", 32'(ir_write), 1);
        step();
        chk("t5b_decode", 32'(state), 1);
        chk("t5b_buserr", 32'(bus_error), 0);
        step();
        step();
        step();
        chk("t5b_ret", retired, 1);

        opcode = LD_OP;
        dmem_ready = 1'b0;
        step();
        step();
        step();
        chk("t6_mem", 32'(state), 3);
        chk("t6_req", 32'(dmem_req), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_state", 32'(state), 0);
        chk("t6_noreq", 32'(dmem_req), 0);
        chk("t6_ret", retired, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
